// File: rtl/motor_move_if.sv
// -----------------------------------------------------------------------------
// motor_move_if
// Bundle of the command handshake and motor-driver outputs of motor_move_ctrl.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_op/cmd_steps must be stable while cmd_valid is
// high. The master may hold cmd_valid high indefinitely; the command is taken
// in the first cycle cmd_ready is high.
//
// Signals:
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  controller can accept a command
//   cmd_op     master->slave  0=STOP 1=FWD 2=BACK 3=LEFT 4=RIGHT, 5-7=STOP
//   cmd_steps  master->slave  number of step periods to run
//   abort      master->slave  terminate the current move early
//   dir_l      slave->master  left motor direction (0=hold, 1/2=rotate)
//   dir_r      slave->master  right motor direction
//   busy       slave->master  high while running or settling
//   done       slave->master  one-cycle completion pulse
//   aborted    slave->master  move ended by abort; held until next accept
//   steps_left slave->master  remaining steps of the current move
//   state      slave->master  debug view of the controller FSM state
// -----------------------------------------------------------------------------
interface motor_move_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_steps;
    logic        abort;
    logic [1:0]  dir_l;
    logic [1:0]  dir_r;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] steps_left;
    logic [1:0]  state;

    modport master (
        output cmd_valid, cmd_op, cmd_steps, abort,
        input  cmd_ready, dir_l, dir_r, busy, done, aborted, steps_left, state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_steps, abort,
        output cmd_ready, dir_l, dir_r, busy, done, aborted, steps_left, state
    );
endinterface

// File: rtl/motor_move_ctrl.sv
// -----------------------------------------------------------------------------
// motor_move_ctrl
// Move sequencer for the two-wheel stepper drive. Accepts one motion command
// at a time, drives the driver direction inputs for an exact number of step
// periods, holds both motors stopped for a settle interval, then pulses done.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   motor_move_if.slave: command handshake, abort, direction outputs,
//         status (busy/done/aborted/steps_left) and debug FSM state
//
// Parameters:
//   STEP_DIV    clk cycles per step period (>= 2)
//   SETTLE_CYC  clk cycles with both directions at 0 after a move (>= 1)
//   RAMP_STEPS  number of initial double-length steps (ramp build only)
//
// Build option:
//   MOTOR_RAMP_EN  when defined, the first min(RAMP_STEPS, cmd_steps) steps of
//                  each move last 2*STEP_DIV cycles; otherwise every step
//                  lasts STEP_DIV cycles.
// -----------------------------------------------------------------------------
module motor_move_ctrl #(
    parameter int STEP_DIV   = 100000,
    parameter int SETTLE_CYC = 50000,
    parameter int RAMP_STEPS = 8
) (
    input logic        clk,
    input logic        rst,
    motor_move_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Divider must hold up to 2*STEP_DIV-1 for the slow ramp periods.
    localparam int DIV_W = $clog2(2 * STEP_DIV);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST_SLOW = DIV_W'(2 * STEP_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST      = SET_W'(SETTLE_CYC - 1);

`ifdef MOTOR_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [SET_W-1:0] set_cnt;
    logic [15:0]      step_cnt;     // steps completed in the current move
    logic [15:0]      steps_left_q;
    logic             aborted_q;
    logic [1:0]       dir_l_q;
    logic [1:0]       dir_r_q;

    logic [DIV_W-1:0] period_last;
    logic             tick;
    logic [3:0]       cmd_dirs;

    // {dir_l, dir_r} for an opcode; all zero means no motion (STOP).
    function automatic logic [3:0] dir_map(input logic [2:0] op);
        case (op)
            3'd1:    dir_map = {2'd1, 2'd2};  // FWD
            3'd2:    dir_map = {2'd2, 2'd1};  // BACK
            3'd3:    dir_map = {2'd2, 2'd2};  // LEFT
            3'd4:    dir_map = {2'd1, 2'd1};  // RIGHT
            default: dir_map = 4'd0;          // STOP and reserved codes
        endcase
    endfunction

    assign cmd_dirs = dir_map(bus.cmd_op);

    // With the ramp disabled RAMP_ON folds the slow-period select away.
    always_comb begin
        period_last = DIV_LAST;
        if (RAMP_ON && (32'(step_cnt) < RAMP_STEPS)) begin
            period_last = DIV_LAST_SLOW;
        end
    end

    assign tick = (div_cnt == period_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            set_cnt      <= '0;
            step_cnt     <= '0;
            steps_left_q <= '0;
            aborted_q    <= 1'b0;
            dir_l_q      <= 2'd0;
            dir_r_q      <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        steps_left_q <= bus.cmd_steps;
                        aborted_q    <= 1'b0;
                        dir_l_q      <= cmd_dirs[3:2];
                        dir_r_q      <= cmd_dirs[1:0];
                        div_cnt      <= '0;
                        step_cnt     <= '0;
                        set_cnt      <= '0;
                        if (cmd_dirs == 4'd0 || bus.cmd_steps == 16'd0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // The final tick wins over a coincident abort so the move
                    // still reports a normal completion.
                    if (tick && steps_left_q == 16'd1) begin
                        steps_left_q <= 16'd0;
                        div_cnt      <= '0;
                        set_cnt      <= '0;
                        state        <= S_SETTLE;
                    end else if (bus.abort) begin
                        aborted_q <= 1'b1;
                        set_cnt   <= '0;
                        state     <= S_SETTLE;
                    end else if (tick) begin
                        steps_left_q <= steps_left_q - 16'd1;
                        step_cnt     <= step_cnt + 16'd1;
                        div_cnt      <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        state <= S_DONE;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Directions drop the moment reset is asserted, not only after the edge.
    assign bus.dir_l      = (state == S_RUN && !rst) ? dir_l_q : 2'd0;
    assign bus.dir_r      = (state == S_RUN && !rst) ? dir_r_q : 2'd0;
    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.busy       = (state == S_RUN) || (state == S_SETTLE);
    assign bus.done       = (state == S_DONE);
    assign bus.aborted    = aborted_q;
    assign bus.steps_left = steps_left_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_motor_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_move_ctrl
// Self-checking bench for motor_move_ctrl with STEP_DIV=4, SETTLE_CYC=3,
// RAMP_STEPS=2. The driver pushes the expected outcome of each accepted
// command into exp_q; the monitor measures each move on the outputs and
// compares against the queue head when done pulses.
// Expected word: {aborted, steps_left, run_cycles, busy_cycles, dir_l, dir_r}
// -----------------------------------------------------------------------------
module tb_motor_move_ctrl;
    localparam int STEP_DIV   = 4;
    localparam int SETTLE_CYC = 3;
    localparam int RAMP_STEPS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   abort_at = -1;
    logic [52:0] exp_q[$];

    motor_move_if bus();

    motor_move_ctrl #(
        .STEP_DIV(STEP_DIV),
        .SETTLE_CYC(SETTLE_CYC),
        .RAMP_STEPS(RAMP_STEPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int step_period(input int idx);
        int per;
        per = STEP_DIV;
`ifdef MOTOR_RAMP_EN
        if (idx < RAMP_STEPS) per = 2 * STEP_DIV;
`endif
        return per;
    endfunction

    function automatic bit is_motion(input int op);
        return (op >= 1 && op <= 4);
    endfunction

    // Number of cycles a full (unaborted) move keeps the motors turning.
    function automatic int total_run(input int op, input int steps);
        int t;
        t = 0;
        if (is_motion(op)) begin
            for (int i = 0; i < steps; i++) t += step_period(i);
        end
        return t;
    endfunction

    // k = index of the RUN cycle (0 = first) in which abort is high, -1 = none.
    function automatic logic [52:0] model(input int op, input int steps, input int k);
        int dl, dr, total, ticks_before, run, sl;
        bit ab;
        dl = 0; dr = 0;
        case (op)
            1: begin dl = 1; dr = 2; end
            2: begin dl = 2; dr = 1; end
            3: begin dl = 2; dr = 2; end
            4: begin dl = 1; dr = 1; end
            default: begin dl = 0; dr = 0; end
        endcase
        if (dl == 0 || steps == 0)
            return {1'b0, 16'(steps), 16'd0, 16'd0, 2'd0, 2'd0};
        total = 0;
        ticks_before = 0;
        for (int i = 0; i < steps; i++) begin
            total += step_period(i);
            if (k >= 0 && (total - 1) < k) ticks_before++;
        end
        if (k >= 0 && k < total - 1) begin
            ab = 1'b1; run = k + 1; sl = steps - ticks_before;
        end else begin
            ab = 1'b0; run = total; sl = 0;
        end
        return {ab, 16'(sl), 16'(run), 16'(run + SETTLE_CYC), 2'(dl), 2'(dr)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int op, input int steps, input int k, input bit hold);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_steps = 16'(steps);
        while (bus.cmd_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: cmd_ready stayed low for %0d cycles, expected high", guard);
            bus.cmd_valid = 1'b0;
            return;
        end
        abort_at = (k >= 0) ? cyc + 1 + k : -1;
        exp_q.push_back(model(op, steps, k));
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d moves pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Abort is asserted for exactly one cycle at the scheduled cycle.
    initial begin
        bus.abort = 1'b0;
        forever begin
            @(negedge clk);
            bus.abort = (abort_at >= 0 && cyc == abort_at);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int run_cnt, bsy_cnt;
        logic [1:0] cap_l, cap_r;
        bit chk_rdy;
        logic [52:0] e;
        run_cnt = 0; bsy_cnt = 0; cap_l = 2'd0; cap_r = 2'd0; chk_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_cnt = 0; bsy_cnt = 0; cap_l = 2'd0; cap_r = 2'd0; chk_rdy = 1'b0;
                continue;
            end
            if (chk_rdy) begin
                chk("ready_after_done", 32'(bus.cmd_ready), 32'd1);
                chk_rdy = 1'b0;
            end
            if (bus.dir_l != 2'd0 || bus.dir_r != 2'd0) begin
                if (run_cnt == 0) begin
                    cap_l = bus.dir_l;
                    cap_r = bus.dir_r;
                end else begin
                    chk("dir_stable", 32'({bus.dir_l, bus.dir_r}), 32'({cap_l, cap_r}));
                end
                chk("busy_with_dir", 32'(bus.busy), 32'd1);
                run_cnt++;
            end
            if (bus.busy) bsy_cnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: done=1 with no move pending, expected done=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("aborted",     32'(bus.aborted),    32'(e[52]));
                    chk("steps_left",  32'(bus.steps_left), 32'(e[51:36]));
                    chk("run_cycles",  32'(run_cnt),        32'(e[35:20]));
                    chk("busy_cycles", 32'(bsy_cnt),        32'(e[19:4]));
                    chk("dir_pair",    32'({cap_l, cap_r}), 32'(e[3:0]));
                    chk("busy_at_done",  32'(bus.busy),      32'd0);
                    chk("ready_at_done", 32'(bus.cmd_ready), 32'd0);
                end
                run_cnt = 0; bsy_cnt = 0; cap_l = 2'd0; cap_r = 2'd0;
                chk_rdy = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int op, steps, k;
        bit hold;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_steps = 16'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",      32'(bus.cmd_ready),  32'd1);
        chk("rst_dir_l",      32'(bus.dir_l),      32'd0);
        chk("rst_dir_r",      32'(bus.dir_r),      32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_aborted",    32'(bus.aborted),    32'd0);
        chk("rst_steps_left", 32'(bus.steps_left), 32'd0);
        rst = 1'b0;

        // Directed moves: normal, zero-length, aborts, back-to-back.
        send(1, 3, -1, 1'b0);
        send(0, 5, -1, 1'b0);
        send(4, 0, -1, 1'b0);
        send(3, 10, 5, 1'b0);
        send(3, 10, total_run(3, 10) - 1, 1'b0);
        send(2, 2, -1, 1'b1);
        send(2, 2, -1, 1'b1);
        send(2, 2, -1, 1'b0);

        // Randomized moves; aborts land no later than the DONE cycle.
        repeat (40) begin
            op    = $urandom_range(0, 7);
            steps = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 9);
            hold  = 1'($urandom_range(0, 1));
            k     = -1;
            if ($urandom_range(0, 2) == 0) begin
                if (total_run(op, steps) == 0) k = 0;
                else k = $urandom_range(0, total_run(op, steps) + SETTLE_CYC);
            end
            send(op, steps, k, hold);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a move.
        send(1, 5, -1, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        abort_at = -1;
        @(negedge clk);
        chk("rstmid_dir_l",      32'(bus.dir_l),      32'd0);
        chk("rstmid_dir_r",      32'(bus.dir_r),      32'd0);
        chk("rstmid_ready",      32'(bus.cmd_ready),  32'd1);
        chk("rstmid_steps_left", 32'(bus.steps_left), 32'd0);
        chk("rstmid_busy",       32'(bus.busy),       32'd0);
        chk("rstmid_done",       32'(bus.done),       32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // Recovery after reset.
        send(4, 2, -1, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
